// File: rtl/hs_stream_arbiter.sv
// ============================================================================
// Module   : hs_stream_arbiter
// Purpose  : NUM_CH-channel valid/last/ready packet arbiter, round-robin on
//            packet boundaries, registered output tagged with source channel.
//            Optional stall timeout with forced release: HS_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_stream_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 32,
   parameter int CH_W    = $clog2(NUM_CH),
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     MIB_MASTER_RESET,
   input  logic [NUM_CH*DATA_W-1:0] i_data,
   input  logic [NUM_CH-1:0]        i_last,
   input  logic [NUM_CH-1:0]        i_valid,
   output logic [NUM_CH-1:0]        o_ready,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_last,
   output logic                     o_valid,
   output logic [CH_W-1:0]          o_ch,
   input  logic                     i_ready,
   output logic                     o_abort
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CH_W-1:0]   r_ptr, w_ptr_nxt;
   logic [CH_W-1:0]   r_grant, w_grant_nxt;
   logic [CH_W-1:0]   w_grant_inc;
   logic [CH_W-1:0]   w_req_idx;
   logic              w_req_found;
   logic [CH_W:0]     w_sum;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_out_free;
   logic              w_accept;
   logic              w_timeout;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [CH_W-1:0]   r_ch;

   if (NUM_CH < 2 || TIMEOUT < 1) begin : g_param_check
      $error("hs_stream_arbiter: NUM_CH must be >= 2 and TIMEOUT >= 1");
   end

   // Scan from the highest offset down so the channel nearest ptr wins.
   always_comb begin
      w_req_found = 1'b0;
      w_req_idx   = '0;
      w_sum       = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         w_sum = {1'b0, r_ptr} + (CH_W+1)'(i);
         if (w_sum >= (CH_W+1)'(NUM_CH)) begin
            w_sum = w_sum - (CH_W+1)'(NUM_CH);
         end
         if (i_valid[w_sum[CH_W-1:0]]) begin
            w_req_found = 1'b1;
            w_req_idx   = w_sum[CH_W-1:0];
         end
      end
   end

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (CH_W'(k) == r_grant) begin
            w_sel_data = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign w_grant_inc = (r_grant == CH_W'(NUM_CH - 1)) ? '0 : r_grant + CH_W'(1);
   assign w_out_free  = !r_valid || i_ready;
   assign w_accept    = (r_state == ST_LOCKED) && i_valid[r_grant] && w_out_free;

`ifdef HS_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_abort;

   // Fires on the TIMEOUT-th consecutive stall cycle of the granted channel.
   assign w_timeout = (r_state == ST_LOCKED) && !i_valid[r_grant] &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
      if (MIB_MASTER_RESET) begin
         r_tmo_cnt <= '0;
         r_abort   <= 1'b0;
      end else begin
         r_abort <= w_timeout;
         if (r_state != ST_LOCKED || w_accept || w_timeout) begin
            r_tmo_cnt <= '0;
         end else if (!i_valid[r_grant]) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         end
      end
   end

   assign o_abort = r_abort;
`else
   assign w_timeout = 1'b0;
   assign o_abort   = 1'b0;
`endif

   always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
      if (MIB_MASTER_RESET) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_grant <= w_grant_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_grant_nxt = r_grant;
      case (r_state)
         ST_IDLE: begin
            if (w_req_found) begin
               w_grant_nxt = w_req_idx;
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if ((w_accept && i_last[r_grant]) || w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_grant_inc;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = '0;
      if (r_state == ST_LOCKED && w_out_free) begin
         o_ready[r_grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge MIB_MASTER_RESET) begin
      if (MIB_MASTER_RESET) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_ch    <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= w_sel_data;
         r_last  <= i_last[r_grant];
         r_ch    <= r_grant;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_ch    = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_hs_stream_arbiter.sv
// Self-checking bench for hs_stream_arbiter: a 4-channel and a 3-channel
// instance, per-channel source queues and an output scoreboard.
`default_nettype none

module tb_hs_stream_arbiter;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic [127:0]  d4 = '0;
   logic [3:0]    v4 = '0, l4 = '0, rdy_o4;
   logic          r4 = 1'b1;
   logic [31:0]   od4;
   logic          ol4, ov4, oa4;
   logic [1:0]    oc4;

   logic [95:0]   d3 = '0;
   logic [2:0]    v3 = '0, l3 = '0, rdy_o3;
   logic          r3 = 1'b1;
   logic [31:0]   od3;
   logic          ol3, ov3, oa3;
   logic [1:0]    oc3;

   logic [32:0]   src [2][4][64];
   int            wr [2][4];
   int            rd [2][4];
   bit            hold [2][4];
   logic [34:0]   exp4 [$];
   logic [34:0]   exp3 [$];
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clk = ~clk;

   hs_stream_arbiter #(.NUM_CH(4), .DATA_W(32)) dut4 (
      .clk(clk), .MIB_MASTER_RESET(rst),
      .i_data(d4), .i_last(l4), .i_valid(v4), .o_ready(rdy_o4),
      .o_data(od4), .o_last(ol4), .o_valid(ov4), .o_ch(oc4),
      .i_ready(r4), .o_abort(oa4)
   );

   hs_stream_arbiter #(.NUM_CH(3), .DATA_W(32)) dut3 (
      .clk(clk), .MIB_MASTER_RESET(rst),
      .i_data(d3), .i_last(l3), .i_valid(v3), .o_ready(rdy_o3),
      .o_data(od3), .o_last(ol3), .o_valid(ov3), .o_ch(oc3),
      .i_ready(r3), .o_abort(oa3)
   );

   // Output scoreboards: every transferred beat must match the queue head.
   always @(negedge clk) begin
      if (!rst && ov4 && r4) begin
         logic [34:0] e;
         n_cmp++;
         if (exp4.size() == 0) begin
            n_bad++;
            $display("FAIL sb4 unexpected beat: got ch=%0d last=%0b data=%h, required none", oc4, ol4, od4);
         end else begin
            e = exp4.pop_front();
            if ({oc4, ol4, od4} !== e) begin
               n_bad++;
               $display("FAIL sb4 beat: got ch=%0d last=%0b data=%h, required ch=%0d last=%0b data=%h",
                        oc4, ol4, od4, e[34:33], e[32], e[31:0]);
            end
         end
      end
      if (!rst && ov3 && r3) begin
         logic [34:0] e;
         n_cmp++;
         if (exp3.size() == 0) begin
            n_bad++;
            $display("FAIL sb3 unexpected beat: got ch=%0d last=%0b data=%h, required none", oc3, ol3, od3);
         end else begin
            e = exp3.pop_front();
            if ({oc3, ol3, od3} !== e) begin
               n_bad++;
               $display("FAIL sb3 beat: got ch=%0d last=%0b data=%h, required ch=%0d last=%0b data=%h",
                        oc3, ol3, od3, e[34:33], e[32], e[31:0]);
            end
         end
      end
   end

   task automatic push_beat(input int p, input int k, input logic last,
                            input logic [31:0] data, input bit expect_out);
      src[p][k][wr[p][k]] = {last, data};
      wr[p][k]++;
      if (expect_out) begin
         if (p == 0) exp4.push_back({2'(k), last, data});
         else        exp3.push_back({2'(k), last, data});
      end
   endtask

   task automatic drive();
      for (int k = 0; k < 4; k++) begin
         if (!hold[0][k] && rd[0][k] < wr[0][k]) begin
            {l4[k], d4[k*32 +: 32]} = src[0][k][rd[0][k]];
            v4[k] = 1'b1;
         end else begin
            {l4[k], d4[k*32 +: 32]} = '0;
            v4[k] = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (!hold[1][k] && rd[1][k] < wr[1][k]) begin
            {l3[k], d3[k*32 +: 32]} = src[1][k][rd[1][k]];
            v3[k] = 1'b1;
         end else begin
            {l3[k], d3[k*32 +: 32]} = '0;
            v3[k] = 1'b0;
         end
      end
   endtask

   // One clock: sample handshakes mid-cycle, advance sources after the edge.
   task automatic tick();
      bit [3:0] a4;
      bit [2:0] a3;
      @(negedge clk);
      a4 = v4 & rdy_o4;
      a3 = v3 & rdy_o3;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (a4[k] && !rst) rd[0][k]++;
      for (int k = 0; k < 3; k++) if (a3[k] && !rst) rd[1][k]++;
      drive();
   endtask

   function automatic bit pending(input int p);
      bit b;
      b = (p == 0) ? (exp4.size() != 0) : (exp3.size() != 0);
      for (int k = 0; k < 4; k++) if (rd[p][k] < wr[p][k]) b = 1'b1;
      return b;
   endfunction

   task automatic wait_done(input int p, input int maxc);
      int c;
      c = 0;
      while (pending(p) && c < maxc) begin
         tick();
         c++;
      end
      n_cmp++;
      if (pending(p)) begin
         n_bad++;
         $display("FAIL drain%0d: beats outstanding after %0d cycles, required none", p, c);
      end
   endtask

   task automatic clear_sources();
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 4; k++) begin
            wr[p][k] = 0;
            rd[p][k] = 0;
            hold[p][k] = 1'b0;
         end
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      clear_sources();
      exp4.delete();
      exp3.delete();
      r4 = 1'b1;
      r3 = 1'b1;
      drive();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_sources();
      push_beat(0, 0, 1'b1, 32'h55, 1'b0);
      push_beat(1, 1, 1'b1, 32'h66, 1'b0);
      drive();
      tick();
      n_cmp++;
      if ({ov4, od4, ol4, oc4, oa4, rdy_o4} !== '0) begin
         n_bad++;
         $display("FAIL reset4 outputs: got valid=%0b data=%h last=%0b ch=%0d abort=%0b ready=%b, required all 0",
                  ov4, od4, ol4, oc4, oa4, rdy_o4);
      end
      n_cmp++;
      if ({ov3, od3, ol3, oc3, oa3, rdy_o3} !== '0) begin
         n_bad++;
         $display("FAIL reset3 outputs: got valid=%0b data=%h ready=%b, required all 0", ov3, od3, rdy_o3);
      end
      reset_dut();
   endtask

   task automatic test_single_packet();
      int first, last_t, cnt;
      reset_dut();
      for (int b = 0; b < 4; b++) push_beat(0, 2, b == 3, 32'hA0 + 32'(b), 1'b1);
      drive();
      first = -1; last_t = -1; cnt = 0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (ov4) begin
            if (first < 0) first = t;
            last_t = t;
            cnt++;
         end
      end
      n_cmp++;
      if (first !== 2) begin
         n_bad++;
         $display("FAIL single first_valid: got cycle %0d, required 2", first);
      end
      n_cmp++;
      if (cnt !== 4 || last_t - first !== 3) begin
         n_bad++;
         $display("FAIL single burst: got %0d valid cycles spanning %0d, required 4 spanning 3", cnt, last_t - first);
      end
      wait_done(0, 20);
   endtask

   task automatic test_round_robin();
      int first, last_t, cnt, run, nbub, bad_gap;
      reset_dut();
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 4; k++)
            for (int b = 0; b < 2; b++)
               push_beat(0, k, b == 1, 32'h100 * k + 32'h10 * p + 32'(b), 1'b1);
      drive();
      first = -1; last_t = -1; cnt = 0; run = 0; nbub = 0; bad_gap = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (ov4) begin
            if (first < 0) first = t;
            if (run > 0) begin
               nbub++;
               if (run != 1) bad_gap++;
            end
            run = 0;
            last_t = t;
            cnt++;
         end else if (first >= 0) begin
            run++;
         end
      end
      n_cmp++;
      if (cnt !== 16 || first !== 2) begin
         n_bad++;
         $display("FAIL rr beats: got %0d beats from cycle %0d, required 16 from cycle 2", cnt, first);
      end
      n_cmp++;
      if (nbub !== 7 || bad_gap !== 0 || last_t !== 24) begin
         n_bad++;
         $display("FAIL rr bubbles: got %0d gaps (%0d not 1 cycle), last cycle %0d, required 7 gaps of 1, last 24",
                  nbub, bad_gap, last_t);
      end
      wait_done(0, 20);
   endtask

   task automatic test_backpressure();
      bit          stalled;
      logic [31:0] held;
      reset_dut();
      for (int b = 0; b < 6; b++) push_beat(0, 0, b == 5, 32'hC0 + 32'(b), 1'b1);
      drive();
      stalled = 1'b0;
      held = '0;
      for (int t = 0; t < 30; t++) begin
         tick();
         r4 = t[0];
         #1;
         if (ov4 && rd[0][0] < wr[0][0]) begin
            n_cmp++;
            if (rdy_o4 !== {3'b000, r4}) begin
               n_bad++;
               $display("FAIL bp ready: got %b with i_ready=%0b, required %b", rdy_o4, r4, {3'b000, r4});
            end
         end
         if (stalled) begin
            n_cmp++;
            if (od4 !== held || ov4 !== 1'b1) begin
               n_bad++;
               $display("FAIL bp hold: got valid=%0b data=%h, required valid=1 data=%h", ov4, od4, held);
            end
         end
         stalled = ov4 && !r4;
         held = od4;
      end
      r4 = 1'b1;
      wait_done(0, 20);
   endtask

   task automatic test_stall();
      int c;
      reset_dut();
      push_beat(0, 1, 1'b0, 32'hB0, 1'b1);
      push_beat(0, 1, 1'b0, 32'hB1, 1'b1);
      push_beat(0, 1, 1'b1, 32'hB2, 1'b1);
      drive();
      c = 0;
      while (rd[0][1] < 1 && c < 20) begin
         tick();
         c++;
      end
      n_cmp++;
      if (rd[0][1] !== 1) begin
         n_bad++;
         $display("FAIL stall start: got %0d beats accepted on ch1, required 1", rd[0][1]);
      end
      hold[0][1] = 1'b1;
      push_beat(0, 0, 1'b1, 32'hD0, 1'b1);
      drive();
      for (int t = 0; t < 50; t++) begin
         tick();
         n_cmp++;
         if (rdy_o4[0] !== 1'b0 || oa4 !== 1'b0) begin
            n_bad++;
            $display("FAIL stall cycle %0d: got ready0=%0b abort=%0b, required 0 0", t, rdy_o4[0], oa4);
         end
      end
      hold[0][1] = 1'b0;
      drive();
      wait_done(0, 30);
   endtask

   task automatic test_reset_mid();
      int c;
      reset_dut();
      push_beat(0, 1, 1'b1, 32'hE0, 1'b1);
      drive();
      wait_done(0, 20);
      for (int b = 0; b < 5; b++) push_beat(0, 2, b == 4, 32'hF0 + 32'(b), b == 0);
      drive();
      c = 0;
      while (rd[0][2] < 2 && c < 20) begin
         tick();
         c++;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({ov4, od4, ol4, oc4, oa4, rdy_o4} !== '0) begin
         n_bad++;
         $display("FAIL rstmid outputs: got valid=%0b data=%h last=%0b ch=%0d ready=%b, required all 0",
                  ov4, od4, ol4, oc4, rdy_o4);
      end
      n_cmp++;
      if (exp4.size() !== 0 || rd[0][2] !== 2) begin
         n_bad++;
         $display("FAIL rstmid progress: got %0d expected beats left, %0d accepted, required 0 and 2",
                  exp4.size(), rd[0][2]);
      end
      clear_sources();
      drive();
      tick();
      tick();
      rst = 1'b0;
      push_beat(0, 0, 1'b1, 32'h1000, 1'b1);
      push_beat(0, 3, 1'b1, 32'h1003, 1'b1);
      drive();
      wait_done(0, 20);
   endtask

   task automatic test_wrap3();
      int seq [$];
      reset_dut();
      push_beat(1, 0, 1'b1, 32'h300, 1'b1);
      push_beat(1, 1, 1'b1, 32'h310, 1'b1);
      push_beat(1, 2, 1'b1, 32'h320, 1'b1);
      push_beat(1, 0, 1'b1, 32'h301, 1'b1);
      drive();
      for (int t = 0; t < 20; t++) begin
         tick();
         if (ov3) seq.push_back(int'(oc3));
      end
      n_cmp++;
      if (seq.size() !== 4) begin
         n_bad++;
         $display("FAIL wrap3 count: got %0d beats, required 4", seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (seq[i] !== i % 3) begin
               n_bad++;
               $display("FAIL wrap3 ch[%0d]: got %0d, required %0d", i, seq[i], i % 3);
            end
         end
      end
      wait_done(1, 10);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_sources();
      drive();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_stall();
      test_reset_mid();
      test_wrap3();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
